// File: rtl/systolic_array.sv
// 4x4 output-stationary systolic array: C = A x B on signed Q8.8 operands, one C element per PE.
// Latency: done rises on the 10th rising edge after reset release; results then frozen until reset.
// No backpressure: operands are consumed every edge until done, then ignored.
module systolic_array #(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     inp_west0,
    input  logic [WIDTH-1:0]     inp_west1,
    input  logic [WIDTH-1:0]     inp_west2,
    input  logic [WIDTH-1:0]     inp_west3,
    input  logic [WIDTH-1:0]     inp_north0,
    input  logic [WIDTH-1:0]     inp_north1,
    input  logic [WIDTH-1:0]     inp_north2,
    input  logic [WIDTH-1:0]     inp_north3,
    output logic                 done,
    output logic [16*WIDTH-1:0]  result
);

    localparam int          N        = 4;
    localparam logic [3:0]  CNT_LAST = 4'd10;

    logic [WIDTH-1:0] west_in  [N];
    logic [WIDTH-1:0] north_in [N];

    assign west_in[0]  = inp_west0;
    assign west_in[1]  = inp_west1;
    assign west_in[2]  = inp_west2;
    assign west_in[3]  = inp_west3;
    assign north_in[0] = inp_north0;
    assign north_in[1] = inp_north1;
    assign north_in[2] = inp_north2;
    assign north_in[3] = inp_north3;

    // The east-most column never forwards a, the south-most row never forwards b.
    logic [WIDTH-1:0] a_q   [N][N-1];
    logic [WIDTH-1:0] a_d   [N][N-1];
    logic [WIDTH-1:0] b_q   [N-1][N];
    logic [WIDTH-1:0] b_d   [N-1][N];
    logic [WIDTH-1:0] acc_q [N][N];
    logic [WIDTH-1:0] acc_d [N][N];
    logic [WIDTH-1:0] a_op  [N][N];
    logic [WIDTH-1:0] b_op  [N][N];
    logic [WIDTH-1:0] term  [N][N];
    logic [3:0]       cnt_q, cnt_d;
    logic             done_q, done_d;

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic signed [2*WIDTH-1:0] prod;

            if (gj == 0) begin : g_west_edge
                assign a_op[gi][gj] = west_in[gi];
            end else begin : g_west_fwd
                assign a_op[gi][gj] = a_q[gi][gj-1];
            end

            if (gi == 0) begin : g_north_edge
                assign b_op[gi][gj] = north_in[gj];
            end else begin : g_north_fwd
                assign b_op[gi][gj] = b_q[gi-1][gj];
            end

            // Arithmetic shift drops the extra Q8.8 fraction; the cast keeps the low word.
            assign prod         = $signed(a_op[gi][gj]) * $signed(b_op[gi][gj]);
            assign term[gi][gj] = WIDTH'(prod >>> FRAC_BITS);
            assign result[(gi*N+gj)*WIDTH +: WIDTH] = acc_q[gi][gj];
        end
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 4'd1;
        done_d = done_q | (cnt_d == CNT_LAST);
        if (!done_q) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc_d[i][j] = acc_q[i][j] + term[i][j];
                end
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N-1; j++) begin
                    a_d[i][j] = a_op[i][j];
                end
            end
            for (int i = 0; i < N-1; i++) begin
                for (int j = 0; j < N; j++) begin
                    b_d[i][j] = b_op[i][j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc_q[i][j] <= '0;
                end
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N-1; j++) begin
                    a_q[i][j] <= '0;
                end
            end
            for (int i = 0; i < N-1; i++) begin
                for (int j = 0; j < N; j++) begin
                    b_q[i][j] <= '0;
                end
            end
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_q    <= a_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_systolic_array.sv
// Randomized bench for systolic_array: a matrix-level model predicts the partial sums after every edge.
module tb_systolic_array;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  inp_west0, inp_west1, inp_west2, inp_west3;
    logic [15:0]  inp_north0, inp_north1, inp_north2, inp_north3;
    logic         done;
    logic [255:0] result;

    always #5 clk = ~clk;

    systolic_array #(.WIDTH(16), .FRAC_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .inp_west0  (inp_west0),
        .inp_west1  (inp_west1),
        .inp_west2  (inp_west2),
        .inp_west3  (inp_west3),
        .inp_north0 (inp_north0),
        .inp_north1 (inp_north1),
        .inp_north2 (inp_north2),
        .inp_north3 (inp_north3),
        .done       (done),
        .result     (result)
    );

    logic [15:0] am [4][4];
    logic [15:0] bm [4][4];
    int          n_edges  = 0;
    bit          chk_en   = 1'b0;
    bit          garbage  = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [15:0] mac_term(logic [15:0] a, logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> 8;
        return p[15:0];
    endfunction

    // Element (i,j) after n edges: term m lands on edge i+j+m; nothing lands after edge 9.
    function automatic logic [15:0] model_c(int i, int j, int n);
        logic [15:0] s;
        int          last;
        s    = '0;
        last = ((n > 10) ? 10 : n) - 1;
        for (int m = 0; m < 4; m++)
            if (i + j + m <= last) s = s + mac_term(am[i][m], bm[m][j]);
        return s;
    endfunction

    function automatic logic [255:0] model_res(int n);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                r[(i*4+j)*16 +: 16] = model_c(i, j, n);
        return r;
    endfunction

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst) begin
                check("cyc_reset_done", {255'd0, done}, 256'd0);
                check("cyc_reset_result", result, 256'd0);
            end else begin
                check("cyc_done", {255'd0, done}, {255'd0, (n_edges >= 10)});
                check("cyc_result", result, model_res(n_edges));
            end
        end
    end

    task automatic drive_edge();
        logic [15:0] w [4];
        logic [15:0] nn [4];
        int k;
        k = n_edges;
        for (int i = 0; i < 4; i++) begin
            if (garbage) begin
                w[i]  = 16'($urandom);
                nn[i] = 16'($urandom);
            end else begin
                w[i]  = (k - i >= 0 && k - i <= 3) ? am[i][k-i] : 16'h0;
                nn[i] = (k - i >= 0 && k - i <= 3) ? bm[k-i][i] : 16'h0;
            end
        end
        inp_west0  = w[0];  inp_west1  = w[1];  inp_west2  = w[2];  inp_west3  = w[3];
        inp_north0 = nn[0]; inp_north1 = nn[1]; inp_north2 = nn[2]; inp_north3 = nn[3];
    endtask

    task automatic step();
        drive_edge();
        @(posedge clk);
        n_edges++;
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        n_edges = 0;
        garbage = 1'b1;
        drive_edge();
        garbage = 1'b0;
        #3;
        check("rst_done", {255'd0, done}, 256'd0);
        check("rst_result", result, 256'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic run_full();
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 8) check("done_not_edge9", {255'd0, done}, 256'd0);
            if (k == 9) check("done_on_edge10", {255'd0, done}, 256'd1);
        end
    endtask

    task automatic load_reference();
        int a_rows [4][4] = '{'{3,2,1,0}, '{7,6,5,4}, '{1,1,9,8}, '{5,4,3,2}};
        int b_cols [4][4] = '{'{1,8,4,0}, '{1,9,5,1}, '{4,1,6,2}, '{5,1,7,3}};
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                am[i][j] = 16'(a_rows[i][j] * 256);
                bm[i][j] = 16'(b_cols[j][i] * 256);
            end
    endtask

    task automatic check_reference(string tag);
        logic [15:0] ref_c [16] = '{16'h1700, 16'h1A00, 16'h1400, 16'h1800,
                                    16'h4B00, 16'h5A00, 16'h4800, 16'h5800,
                                    16'h2D00, 16'h3F00, 16'h4B00, 16'h5D00,
                                    16'h3100, 16'h3A00, 16'h2E00, 16'h3800};
        for (int e = 0; e < 16; e++)
            check($sformatf("%s_c%0d%0d", tag, e / 4, e % 4),
                  {240'd0, result[e*16 +: 16]}, {240'd0, ref_c[e]});
    endtask

    task automatic set_identity_b();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                bm[i][j] = (i == j) ? 16'h0100 : 16'h0000;
    endtask

    task automatic randomize_mats();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                am[i][j] = 16'($urandom);
                bm[i][j] = 16'($urandom);
            end
    endtask

    initial begin
        logic [255:0] held;
        #1;
        chk_en = 1'b1;

        // Reset and all-zero operands
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                am[i][j] = '0;
                bm[i][j] = '0;
            end
        do_reset();
        run_full();
        check("zero_result", result, 256'd0);

        // Reference product
        load_reference();
        do_reset();
        run_full();
        check_reference("ref");

        // Freeze after done
        held    = result;
        garbage = 1'b1;
        for (int k = 0; k < 5; k++) step();
        garbage = 1'b0;
        check("freeze_result", result, held);
        check("freeze_done", {255'd0, done}, 256'd1);

        // Mid-run reset, then full rerun
        do_reset();
        for (int k = 0; k < 5; k++) step();
        do_reset();
        run_full();
        check_reference("rerun");

        // Negative fraction times identity
        randomize_mats();
        set_identity_b();
        am[0][0] = 16'hFF80;
        do_reset();
        run_full();
        check("neg_half", {240'd0, result[15:0]}, {240'd0, 16'hFF80});

        // 1.5 x 0.5
        set_identity_b();
        am[0][0] = 16'h0180;
        bm[0][0] = 16'h0080;
        do_reset();
        run_full();
        check("frac_mul", {240'd0, result[15:0]}, {240'd0, 16'h00C0});

        // Accumulator wraps modulo 2^16
        randomize_mats();
        for (int m = 0; m < 4; m++) begin
            am[0][m] = 16'h7F00;
            bm[m][0] = 16'h0400;
        end
        do_reset();
        run_full();
        check("wrap_sum", {240'd0, result[15:0]}, {240'd0, 16'hF000});

        // Random matrices, with a few extra zero-padded edges
        for (int t = 0; t < 6; t++) begin
            randomize_mats();
            do_reset();
            run_full();
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) step();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
